// File: rtl/apb_waitstate_slave.sv
// rtl/apb_waitstate_slave.sv - APB completer with 8-bit register file, programmable wait states and PSLVERR
//
// Ports:
//   PCLK      in   clock, all state updates on the rising edge
//   PRESETn   in   asynchronous active-low reset
//   PSEL      in   completer select from the bridge
//   PENABLE   in   access-phase strobe
//   PWRITE    in   1 = write, 0 = read
//   PADDR     in   8-bit register address; addresses >= DEPTH respond with PSLVERR
//   PWDATA    in   8-bit write data
//   PRDATA    out  read data, non-zero only in the single PREADY cycle of a good read
//   PREADY    out  registered transfer-complete, high for exactly one cycle per transfer
//   PSLVERR   out  error response, only while PREADY is high
module apb_waitstate_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);
  localparam logic [3:0] WS_L    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_wdata;
  logic            r_write;
  logic            r_err;
  logic [7:0]      r_prdata;
  logic            r_pready;
  logic            r_pslverr;
  logic [7:0]      r_mem [DEPTH];

  logic            w_setup;
  logic            w_addr_err;
  logic            w_mem_we;
  logic [7:0]      w_rd_setup;
  logic [7:0]      w_rd_latched;

  assign w_setup    = PSEL & ~PENABLE;
  assign w_addr_err = ({1'b0, PADDR} >= DEPTH_L);
  // Writes commit on the edge that ends the ACCESS cycle, so a read set up
  // in the very next cycle already sees the new value.
  assign w_mem_we   = (r_state == ST_ACCESS) & r_write & ~r_err;

  // Read data for the two ways into ACCESS: straight from the setup phase
  // (no wait states) or from the latched request at the end of WAIT.
  // Writes and error transfers return zero.
  always_comb begin
    w_rd_setup   = 8'h00;
    w_rd_latched = 8'h00;
    if (!PWRITE && !w_addr_err) begin
      w_rd_setup = r_mem[PADDR[AW-1:0]];
    end
    if (!r_write && !r_err) begin
      w_rd_latched = r_mem[r_addr];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= 8'h00;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_prdata  <= 8'h00;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      // Response outputs live for exactly one cycle; every path that does
      // not enter ACCESS leaves them cleared.
      r_prdata  <= 8'h00;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // PSEL&PENABLE without a preceding setup is not a transfer.
          if (w_setup) begin
            r_addr  <= PADDR[AW-1:0];
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_err   <= w_addr_err;
            if (WS_L == 4'd0) begin
              r_state   <= ST_ACCESS;
              r_pready  <= 1'b1;
              r_pslverr <= w_addr_err;
              r_prdata  <= w_rd_setup;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WS_L;
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            // Master abandoned the transfer: no write, no response.
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else if (PENABLE) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state   <= ST_ACCESS;
              r_pready  <= 1'b1;
              r_pslverr <= r_err;
              r_prdata  <= w_rd_latched;
            end
          end
          // PSEL high with PENABLE low mid-transfer simply holds the count.
        end
        ST_ACCESS: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_waitstate_slave.sv
// tb/tb_apb_waitstate_slave.sv - randomized self-checking bench for apb_waitstate_slave
module tb_apb_waitstate_slave;

  localparam int DEPTH = 64;
  localparam int WS_A  = 2;
  localparam int WS_B  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [2];
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  logic       exp_ready [2];
  logic [7:0] exp_rdata [2];
  logic       exp_err   [2];
  logic [7:0] model [2][256];

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  apb_waitstate_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_dut_ws (
    .PCLK(clk), .PRESETn(rst_n[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_waitstate_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_dut_nows (
    .PCLK(clk), .PRESETn(rst_n[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle, both completers must match what the model says.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_pready_c%0d", d, cyc), {7'd0, pready[d]}, {7'd0, exp_ready[d]});
        chk($sformatf("d%0d_pslverr_c%0d", d, cyc), {7'd0, pslverr[d]}, {7'd0, exp_err[d]});
        chk($sformatf("d%0d_prdata_c%0d", d, cyc), prdata[d], exp_rdata[d]);
      end
    end
  end

  task automatic clear_model(input int d);
    for (int i = 0; i < 256; i++) model[d][i] = 8'h00;
  endtask

  task automatic drive_idle(input int d, input bit stray);
    psel[d]      = stray;
    penable[d]   = stray;
    pwrite[d]    = 1'($urandom);
    paddr[d]     = 8'($urandom);
    pwdata[d]    = 8'($urandom);
    exp_ready[d] = 1'b0;
    exp_rdata[d] = 8'h00;
    exp_err[d]   = 1'b0;
  endtask

  task automatic idle_cycle(input int d, input bit stray);
    @(posedge clk); #1;
    drive_idle(d, stray);
    drive_idle(1 - d, 1'b0);
  endtask

  task automatic release_reset(input int d);
    repeat (2) @(posedge clk);
    #1;
    rst_n[d] = 1'b1;
  endtask

  // One transfer: setup cycle, then access cycles until the response, which
  // must come exactly WS+1 cycles after setup. abort_k drops PSEL in access
  // cycle abort_k; rst_k pulls reset low in access cycle rst_k.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] dat,
                      input int abort_k, input int rst_k,
                      output logic [7:0] rd, output logic er, output logic rdy);
    int   w;
    logic bad;
    w   = (d == 0) ? WS_A : WS_B;
    bad = (int'(a) >= DEPTH);
    rd  = 8'h00;
    er  = 1'b0;
    rdy = 1'b0;
    @(posedge clk); #1;
    drive_idle(1 - d, 1'b0);
    psel[d]      = 1'b1;
    penable[d]   = 1'b0;
    pwrite[d]    = wr;
    paddr[d]     = a;
    pwdata[d]    = dat;
    exp_ready[d] = 1'b0;
    exp_rdata[d] = 8'h00;
    exp_err[d]   = 1'b0;
    for (int k = 1; k <= w + 1; k++) begin
      @(posedge clk); #1;
      // The completer must use what it latched at setup, not the live bus.
      pwrite[d] = 1'($urandom);
      paddr[d]  = 8'($urandom);
      pwdata[d] = 8'($urandom);
      if (k == abort_k) begin
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        return;
      end
      penable[d] = 1'b1;
      if (k == w + 1) begin
        exp_ready[d] = 1'b1;
        exp_err[d]   = bad;
        exp_rdata[d] = (wr || bad) ? 8'h00 : model[d][a];
      end
      if (k == rst_k) begin
        #1;
        if (k == w + 1) chk("pready_before_reset", {7'd0, pready[d]}, 8'h01);
        rst_n[d]     = 1'b0;
        psel[d]      = 1'b0;
        penable[d]   = 1'b0;
        exp_ready[d] = 1'b0;
        exp_rdata[d] = 8'h00;
        exp_err[d]   = 1'b0;
        clear_model(d);
        #1;
        chk("async_reset_pready", {7'd0, pready[d]}, 8'h00);
        chk("async_reset_pslverr", {7'd0, pslverr[d]}, 8'h00);
        chk("async_reset_prdata", prdata[d], 8'h00);
        return;
      end
      if (k == w + 1) begin
        @(negedge clk);
        rd  = prdata[d];
        er  = pslverr[d];
        rdy = pready[d];
        if (wr && !bad) model[d][a] = dat;
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    logic       rdy;
    int         d;
    int         w;
    int         ab;
    int         rk;
    bit         wr;
    logic [7:0] a;
    logic [7:0] dat;

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b1;
      drive_idle(i, 1'b0);
      clear_model(i);
    end
    #2;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    chk_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    chk("rst_pready", {7'd0, pready[0]}, 8'h00);
    chk("rst_pslverr", {7'd0, pslverr[0]}, 8'h00);
    chk("rst_prdata", prdata[0], 8'h00);

    xfer(0, 1'b0, 8'h00, 8'h00, 0, 0, rd, er, rdy);
    chk("rst_read0_data", rd, 8'h00);
    chk("rst_read0_ready", {7'd0, rdy}, 8'h01);

    xfer(0, 1'b1, 8'h10, 8'hA5, 0, 0, rd, er, rdy);
    chk("wr10_ready", {7'd0, rdy}, 8'h01);
    chk("wr10_err", {7'd0, er}, 8'h00);
    xfer(0, 1'b0, 8'h10, 8'h00, 0, 0, rd, er, rdy);
    chk("rd10_data", rd, 8'hA5);
    chk("rd10_err", {7'd0, er}, 8'h00);

    xfer(0, 1'b1, 8'h40, 8'h3C, 0, 0, rd, er, rdy);
    chk("wr40_err", {7'd0, er}, 8'h01);
    chk("wr40_ready", {7'd0, rdy}, 8'h01);
    xfer(0, 1'b0, 8'h40, 8'h00, 0, 0, rd, er, rdy);
    chk("rd40_data", rd, 8'h00);
    chk("rd40_err", {7'd0, er}, 8'h01);
    xfer(0, 1'b0, 8'h00, 8'h00, 0, 0, rd, er, rdy);
    chk("rd00_data", rd, 8'h00);
    chk("rd00_err", {7'd0, er}, 8'h00);

    xfer(1, 1'b1, 8'h01, 8'h11, 0, 0, rd, er, rdy);
    chk("ws0_wr01_ready", {7'd0, rdy}, 8'h01);
    xfer(1, 1'b0, 8'h01, 8'h00, 0, 0, rd, er, rdy);
    chk("ws0_rd01_ready", {7'd0, rdy}, 8'h01);
    chk("ws0_rd01_data", rd, 8'h11);

    xfer(0, 1'b1, 8'h05, 8'h77, 1, 0, rd, er, rdy);
    idle_cycle(0, 1'b1);
    idle_cycle(0, 1'b0);
    xfer(0, 1'b0, 8'h05, 8'h00, 0, 0, rd, er, rdy);
    chk("abort_rd05_data", rd, 8'h00);

    xfer(0, 1'b1, 8'h10, 8'h5A, 0, 1, rd, er, rdy);
    release_reset(0);
    xfer(0, 1'b0, 8'h10, 8'h00, 0, 0, rd, er, rdy);
    chk("rstwait_rd10_data", rd, 8'h00);

    xfer(0, 1'b1, 8'h22, 8'h99, 0, 0, rd, er, rdy);
    xfer(0, 1'b0, 8'h22, 8'h00, 0, WS_A + 1, rd, er, rdy);
    release_reset(0);
    xfer(0, 1'b0, 8'h22, 8'h00, 0, 0, rd, er, rdy);
    chk("rstacc_rd22_data", rd, 8'h00);

    xfer(1, 1'b0, 8'h01, 8'h00, 0, WS_B + 1, rd, er, rdy);
    release_reset(1);
    xfer(1, 1'b0, 8'h01, 8'h00, 0, 0, rd, er, rdy);
    chk("ws0_rstacc_rd01_data", rd, 8'h00);

    for (int n = 0; n < 400; n++) begin
      d   = int'($urandom_range(0, 1));
      w   = (d == 0) ? WS_A : WS_B;
      wr  = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      dat = 8'($urandom);
      ab  = (w > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, w)) : 0;
      rk  = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, w + 1)) : 0;
      xfer(d, wr, a, dat, ab, rk, rd, er, rdy);
      if (rk != 0 && (ab == 0 || ab > rk)) release_reset(d);
      repeat ($urandom_range(0, 2)) idle_cycle(d, 1'($urandom));
    end

    repeat (3) idle_cycle(0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
